// File: rtl/alu_pkg.sv
// Shared types for the ALU shifter datapath: opcode encoding, per-beat control
// flags and the rule that spreads the mux levels across pipeline stages.
package alu_pkg;

    localparam int SHIFT_OP_W = 3;

    typedef enum logic [SHIFT_OP_W-1:0] {
        SLL = 3'b000,
        SRL = 3'b001,
        SRA = 3'b010,
        ROL = 3'b011,
        ROR = 3'b100
    } shift_op_e;

    typedef struct packed {
        logic [SHIFT_OP_W-1:0] op;
        logic                  big;
        logic                  carry;
        logic                  sign;
        logic                  err;
        logic                  zero;
    } shift_ctrl_t;

    function automatic logic shift_op_legal(input logic [SHIFT_OP_W-1:0] op);
        return op <= ROR;
    endfunction

    // Levels are handed out by ceil division, highest weight in stage 0.
    function automatic int stage_level_hi(input int l, input int stages, input int s);
        return l - 1 - s * ((l + stages - 1) / stages);
    endfunction

    function automatic int stage_level_lo(input int l, input int stages, input int s);
        int lo;
        lo = l - (s + 1) * ((l + stages - 1) / stages);
        return (lo < 0) ? 0 : lo;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One pipeline stage of the shifter: mux levels LEVEL_HI down to LEVEL_LO plus
// the carry update. An empty range (LEVEL_LO > LEVEL_HI) passes the beat through.
module shift_stage
    import alu_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int LEVEL_LO = 0,
    parameter int LEVEL_HI = 0
) (
    input  logic [WIDTH-1:0]         y_in,
    input  logic [$clog2(WIDTH)-1:0] amt_in,
    input  shift_ctrl_t              ctrl_in,
    output logic [WIDTH-1:0]         y_out,
    output logic [$clog2(WIDTH)-1:0] amt_out,
    output shift_ctrl_t              ctrl_out
);

    localparam int NLVL = (LEVEL_HI >= LEVEL_LO) ? (LEVEL_HI - LEVEL_LO + 1) : 0;

    logic [WIDTH-1:0] y_chain [NLVL+1];
    logic             c_chain [NLVL+1];

    assign y_chain[0] = y_in;
    assign c_chain[0] = ctrl_in.carry;

    for (genvar g = 0; g < NLVL; g++) begin : g_lvl
        localparam int LVL = LEVEL_HI - g;
        localparam int SH  = 1 << LVL;

        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] q;
        logic             c;

        assign p = y_chain[g];

        // Every applied level overwrites the carry, so the lowest applied
        // weight leaves exactly the last bit that fell off the end.
        always_comb begin
            q = p;
            c = c_chain[g];
            if (amt_in[LVL]) begin
                case (ctrl_in.op)
                    SLL: begin
                        q = p << SH;
                        c = p[WIDTH-SH];
                    end
                    SRL: begin
                        q = p >> SH;
                        c = p[SH-1];
                    end
                    SRA: begin
                        q = ctrl_in.sign ? ~(~p >> SH) : (p >> SH);
                        c = p[SH-1];
                    end
                    ROL: begin
                        q = (p << SH) | (p >> (WIDTH - SH));
                        c = q[0];
                    end
                    ROR: begin
                        q = (p >> SH) | (p << (WIDTH - SH));
                        c = q[WIDTH-1];
                    end
                    default: ;
                endcase
            end
        end

        assign y_chain[g+1] = q;
        assign c_chain[g+1] = c;
    end

    always_comb begin
        ctrl_out       = ctrl_in;
        ctrl_out.carry = c_chain[NLVL];
    end

    assign y_out   = y_chain[NLVL];
    assign amt_out = amt_in;

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined shift/rotate unit with saturating amounts and carry/zero/err flags.
// Handshake: a beat moves into a stage when the upstream side is valid and the
// stage is ready; a stage is ready when it is empty or its successor is ready.
module pipelined_barrel_shifter
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_a,
    input  logic [WIDTH-1:0]      in_b,
    input  logic [SHIFT_OP_W-1:0] in_op,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_y,
    output logic                  out_carry,
    output logic                  out_zero,
    output logic                  out_err
);

    localparam int L = $clog2(WIDTH);

    typedef struct packed {
        logic [WIDTH-1:0] y;
        logic [L-1:0]     amt;
        shift_ctrl_t      ctrl;
    } stage_payload_t;

    stage_payload_t entry;
    stage_payload_t d [STAGES];
    stage_payload_t q [STAGES];
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] v_in;
    logic [STAGES:0]   rdy;

    logic big;
    assign big = |in_b[WIDTH-1:L];

    // Saturated and illegal cases are resolved up front; clearing the amount
    // lets the mux stages pass them through untouched.
    always_comb begin
        entry            = '0;
        entry.y          = in_a;
        entry.amt        = in_b[L-1:0];
        entry.ctrl.op    = in_op;
        entry.ctrl.big   = big;
        entry.ctrl.sign  = in_a[WIDTH-1];
        if (!shift_op_legal(in_op)) begin
            entry.ctrl.err = 1'b1;
            entry.amt      = '0;
        end else if (big) begin
            case (in_op)
                SLL, SRL: begin
                    entry.y   = '0;
                    entry.amt = '0;
                end
                SRA: begin
                    entry.y          = {WIDTH{in_a[WIDTH-1]}};
                    entry.ctrl.carry = in_a[WIDTH-1];
                    entry.amt        = '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rdy         = '0;
        v_in        = '0;
        rdy[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            rdy[k] = !valid_q[k] || rdy[k+1];
        end
        v_in[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            v_in[k] = valid_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam bit LAST = (k == STAGES - 1);

        stage_payload_t   src;
        logic [WIDTH-1:0] y_o;
        logic [L-1:0]     amt_o;
        shift_ctrl_t      ctrl_o;
        shift_ctrl_t      ctrl_fix;

        if (k == 0) begin : g_head
            assign src = entry;
        end else begin : g_body
            assign src = q[k-1];
        end

        shift_stage #(
            .WIDTH    (WIDTH),
            .LEVEL_LO (stage_level_lo(L, STAGES, k)),
            .LEVEL_HI (stage_level_hi(L, STAGES, k))
        ) u_shift_stage (
            .y_in     (src.y),
            .amt_in   (src.amt),
            .ctrl_in  (src.ctrl),
            .y_out    (y_o),
            .amt_out  (amt_o),
            .ctrl_out (ctrl_o)
        );

        always_comb begin
            ctrl_fix      = ctrl_o;
            ctrl_fix.zero = LAST ? (y_o == '0) : 1'b0;
        end

        assign d[k] = {y_o, amt_o, ctrl_fix};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (rdy[k]) begin
                    valid_q[k] <= v_in[k];
                    if (v_in[k]) begin
                        q[k] <= d[k];
                    end
                end
            end
        end
    end

    assign in_ready  = rdy[0] && !rst;
    assign out_valid = valid_q[STAGES-1];
    assign out_y     = q[STAGES-1].y;
    assign out_carry = q[STAGES-1].ctrl.carry;
    assign out_zero  = q[STAGES-1].ctrl.zero;
    assign out_err   = q[STAGES-1].ctrl.err;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Bench for pipelined_barrel_shifter (WIDTH=32, STAGES=2): directed vectors,
// random traffic with random backpressure, stall hold and mid-flight reset.
module tb_pipelined_barrel_shifter;

    localparam int WIDTH  = 32;
    localparam int STAGES = 2;
    localparam int EW     = WIDTH + 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [2:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
    logic             out_carry;
    logic             out_zero;
    logic             out_err;

    logic [EW-1:0] exp_q[$];
    int            total     = 0;
    int            bad       = 0;
    int            pop_count = 0;
    bit            rand_ready = 1'b0;

    pipelined_barrel_shifter #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_carry (out_carry),
        .out_zero  (out_zero),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    // Reference: {err, zero, carry, y}
    function automatic logic [EW-1:0] ref_model(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic [2:0] op);
        logic [WIDTH-1:0] y;
        logic [WIDTH-1:0] t;
        logic             c;
        logic             e;
        logic             big;
        int               n;
        n   = int'(b[4:0]);
        big = |b[WIDTH-1:5];
        y   = a;
        c   = 1'b0;
        e   = 1'b0;
        case (op)
            3'd0: if (big) y = '0;
                  else if (n != 0) begin
                      y = a << n;
                      t = a >> (WIDTH - n);
                      c = t[0];
                  end
            3'd1: if (big) y = '0;
                  else if (n != 0) begin
                      y = a >> n;
                      t = a >> (n - 1);
                      c = t[0];
                  end
            3'd2: if (big) begin
                      y = {WIDTH{a[WIDTH-1]}};
                      c = a[WIDTH-1];
                  end else if (n != 0) begin
                      y = $signed(a) >>> n;
                      t = a >> (n - 1);
                      c = t[0];
                  end
            3'd3: if (n != 0) begin
                      y = (a << n) | (a >> (WIDTH - n));
                      c = y[0];
                  end
            3'd4: if (n != 0) begin
                      y = (a >> n) | (a << (WIDTH - n));
                      c = y[WIDTH-1];
                  end
            default: e = 1'b1;
        endcase
        return {e, (y == '0), c, y};
    endfunction

    task automatic check(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    // Scoreboard: a result transfers at the edge following a negedge where
    // out_valid & out_ready hold, since out_ready only moves just after posedge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            total++;
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_out observed=%0h expected=none", out_y);
            end
            if (exp_q.size() != 0) begin
                logic [EW-1:0] exp;
                exp = exp_q.pop_front();
                pop_count++;
                total++;
                assert ({out_err, out_zero, out_carry, out_y} === exp) else begin
                    bad++;
                    $error("FAIL result observed=%0h expected=%0h",
                           {out_err, out_zero, out_carry, out_y}, exp);
                end
            end
        end
    end

    // Drives one beat and returns 1 time unit after the edge that accepted it.
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [2:0] op);
        logic acc;
        int   budget;
        acc      = 1'b0;
        budget   = 0;
        in_a     = a;
        in_b     = b;
        in_op    = op;
        in_valid = 1'b1;
        while (!acc && budget < 100) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            budget++;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
        check_bit("accept_timeout", acc, 1'b1);
        if (acc) exp_q.push_back(ref_model(a, b, op));
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget    = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && budget < 200) begin
            @(posedge clk);
            #1;
            budget++;
        end
        check_bit("drain_empty", exp_q.size() == 0, 1'b1);
    endtask

    function automatic logic [WIDTH-1:0] rand_amount();
        case ($urandom_range(0, 3))
            0:       return WIDTH'($urandom_range(0, 31));
            1:       return '0;
            2:       return WIDTH'($urandom_range(32, 100));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [WIDTH-1:0] hold_y;
        int               c0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = '0;
        out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check_bit("rst_out_valid", out_valid, 1'b0);
        check_bit("rst_in_ready", in_ready, 1'b0);
        check("rst_out_bus", {out_err, out_zero, out_carry, out_y}, '0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_bit("idle_in_ready", in_ready, 1'b1);

        // Latency: result visible two cycles after the accepting cycle
        send(32'h0A0A0A0A, 32'd4, 3'd0);
        @(negedge clk);
        check_bit("latency_cycle1", out_valid, 1'b0);
        @(negedge clk);
        check_bit("latency_cycle2", out_valid, 1'b1);
        drain();

        // Directed vectors, back to back
        send(32'h0A0A0A0A, 32'd27,        3'd1);
        send(32'h80000000, 32'h0A0A0A0A,  3'd2);
        send(32'h0A0A0A0A, 32'h0A0A0A0A,  3'd0);
        send(32'h00000001, 32'd33,        3'd4);
        send(32'h80000001, 32'd1,         3'd3);
        send(32'h12345678, 32'd5,         3'd7);
        send(32'h12345678, 32'd0,         3'd0);
        send(32'h7FFFFFFF, 32'd40,        3'd2);
        send(32'hDEADBEEF, 32'h20,        3'd3);
        send(32'h80000000, 32'd31,        3'd2);
        send(32'h00000001, 32'd31,        3'd0);
        send(32'h00000000, 32'd3,         3'd4);
        drain();

        // Random traffic with random backpressure and bubbles
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            send($urandom, rand_amount(), 3'($urandom_range(0, 7)));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
                out_ready = 1'($urandom_range(0, 1));
            end
        end
        rand_ready = 1'b0;
        drain();

        // Backpressure: two beats fill the pipe, the third is refused
        out_ready = 1'b0;
        send(32'h00000011, 32'd1, 3'd0);
        send(32'h00000022, 32'd2, 3'd1);
        in_a     = 32'h00000033;
        in_b     = 32'd3;
        in_op    = 3'd3;
        in_valid = 1'b1;
        hold_y   = exp_q[0][WIDTH-1:0];
        repeat (3) begin
            @(negedge clk);
            check_bit("full_in_ready", in_ready, 1'b0);
            check_bit("full_out_valid", out_valid, 1'b1);
            check("full_hold_y", EW'(out_y), EW'(hold_y));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        c0 = pop_count;
        @(negedge clk);
        check_bit("release_in_ready", in_ready, 1'b1);
        exp_q.push_back(ref_model(32'h00000033, 32'd3, 3'd3));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("release_one_per_cycle", EW'(pop_count - c0), EW'(3));
        drain();

        // Reset with two beats in flight
        send(32'hAAAA5555, 32'd7, 3'd3);
        send(32'h5555AAAA, 32'd9, 3'd4);
        rst = 1'b1;
        #1;
        check_bit("midrst_out_valid", out_valid, 1'b0);
        check_bit("midrst_in_ready", in_ready, 1'b0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_bit("post_rst_no_stale", out_valid, 1'b0);
        end
        @(posedge clk);
        #1;
        send(32'hF0F0F0F0, 32'd8, 3'd1);
        @(negedge clk);
        check_bit("post_rst_latency1", out_valid, 1'b0);
        @(negedge clk);
        check_bit("post_rst_latency2", out_valid, 1'b1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
